// File: rtl/mux_n_reg_rr.sv
// N-channel registered mux with valid/ready output, direct-select or round-robin source choice.
// One output register; a new word is loaded whenever the held word is absent or being consumed.
module mux_n_reg_rr #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ack,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_chan,
  output logic                    sel_err
);

  localparam int NSEL = 2**SEL_W;
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [SEL_W-1:0] r_chan;
  logic [SEL_W-1:0] r_ptr;
  logic             r_sel_err;

  logic [NSEL-1:0]  w_vext;
  logic             w_load;
  logic             w_sel_oor;
  logic             w_rr_found;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_grant;
  logic [SEL_W-1:0] w_gidx;
  logic [WIDTH-1:0] w_gdata;
  logic [SEL_W:0]   w_ptr_sum;
  logic [SEL_W-1:0] w_ptr_nxt;

  // Pad in_valid to the full select range so upper codes read as not-valid.
  assign w_vext    = NSEL'(in_valid);
  assign w_load    = !r_valid || out_ready;
  assign w_sel_oor = {1'b0, sel} >= NUM_IN_W;

  always_comb begin : rr_search
    logic [SEL_W:0] c;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    c          = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      c = {1'b0, r_ptr} + (SEL_W+1)'(i);
      if (c >= NUM_IN_W) c = c - NUM_IN_W;
      if (!w_rr_found && w_vext[c[SEL_W-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = c[SEL_W-1:0];
      end
    end
  end

  assign w_grant = mode ? w_rr_found : (!w_sel_oor && w_vext[sel]);
  assign w_gidx  = mode ? w_rr_idx : sel;

  always_comb begin
    w_gdata = '0;
    for (int k = 0; k < NUM_IN; k++)
      if (w_gidx == SEL_W'(k)) w_gdata = in_data[k*WIDTH +: WIDTH];
  end

  // Pointer advances past the winner, wrapping at NUM_IN (not necessarily a power of two).
  always_comb begin
    w_ptr_sum = {1'b0, w_rr_idx} + 1'b1;
    w_ptr_nxt = (w_ptr_sum >= NUM_IN_W) ? '0 : w_ptr_sum[SEL_W-1:0];
  end

  always_comb begin
    in_ack = '0;
    for (int k = 0; k < NUM_IN; k++)
      in_ack[k] = rst_n && w_load && w_grant && (w_gidx == SEL_W'(k));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_chan    <= '0;
      r_ptr     <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= !mode && w_sel_oor;
      if (w_load) begin
        if (w_grant) begin
          r_data  <= w_gdata;
          r_chan  <= w_gidx;
          r_valid <= 1'b1;
          if (mode) r_ptr <= w_ptr_nxt;
        end else begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_chan  = r_chan;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_mux_n_reg_rr.sv
// Bench for mux_n_reg_rr: a 4-channel and a 3-channel instance share stimulus and are
// compared every cycle against a queue-free behavioural model, plus literal spot checks.
module tb_mux_n_reg_rr;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_valid;
  logic [1:0]     sel;
  logic           mode;
  logic           out_ready;

  logic [3:0]   ack4;
  logic [W-1:0] od4;
  logic         ov4;
  logic [1:0]   oc4;
  logic         se4;
  logic [2:0]   ack3;
  logic [W-1:0] od3;
  logic         ov3;
  logic [1:0]   oc3;
  logic         se3;

  always #5 clk = ~clk;

  mux_n_reg_rr #(.WIDTH(W), .NUM_IN(4), .SEL_W(2)) d4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ack(ack4),
    .sel(sel), .mode(mode), .out_ready(out_ready), .out_data(od4), .out_valid(ov4),
    .out_chan(oc4), .sel_err(se4));

  mux_n_reg_rr #(.WIDTH(W), .NUM_IN(3), .SEL_W(2)) d3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[3*W-1:0]), .in_valid(in_valid[2:0]), .in_ack(ack3),
    .sel(sel), .mode(mode), .out_ready(out_ready), .out_data(od3), .out_valid(ov3),
    .out_chan(oc3), .sel_err(se3));

  int errors = 0;
  int checks = 0;

  // Model state per instance (0 = 4 channels, 1 = 3 channels)
  bit          m_ov[2];
  logic [31:0] m_od[2];
  int          m_oc[2];
  int          m_p[2];
  bit          m_se[2];
  bit          n_ov[2];
  logic [31:0] n_od[2];
  int          n_oc[2];
  int          n_p[2];
  bit          n_se[2];
  logic [3:0]  e_ack[2];
  logic [3:0]  last_ack4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] chan_data(input int k);
    logic [4*W-1:0] d;
    d = in_data;
    return d[k*W +: W];
  endfunction

  // Next state from the rules: pick a winner, capture it if the output slot is free.
  task automatic model_eval(input int inst);
    int  n, g;
    bit  found, load;
    n = (inst == 0) ? 4 : 3;
    n_ov[inst] = m_ov[inst]; n_od[inst] = m_od[inst]; n_oc[inst] = m_oc[inst];
    n_p[inst] = m_p[inst];   n_se[inst] = 1'b0;       e_ack[inst] = 4'b0;
    if (!rst_n) begin
      n_ov[inst] = 0; n_od[inst] = 0; n_oc[inst] = 0; n_p[inst] = 0;
      return;
    end
    load  = !m_ov[inst] || out_ready;
    found = 0; g = 0;
    if (mode) begin
      for (int i = 0; i < n; i++)
        if (!found && in_valid[(m_p[inst] + i) % n]) begin found = 1; g = (m_p[inst] + i) % n; end
    end else begin
      n_se[inst] = (int'(sel) >= n);
      if (int'(sel) < n && in_valid[sel]) begin found = 1; g = int'(sel); end
    end
    if (load) begin
      if (found) begin
        e_ack[inst][g] = 1'b1;
        n_ov[inst] = 1; n_od[inst] = chan_data(g); n_oc[inst] = g;
        if (mode) n_p[inst] = (g + 1) % n;
      end else begin
        n_ov[inst] = 0;
      end
    end
  endtask

  // One clock: check combinational acks mid-cycle, then registered outputs after the edge.
  task automatic step();
    @(negedge clk);
    model_eval(0);
    model_eval(1);
    last_ack4 = ack4;
    chk("ack4", {28'b0, ack4}, {28'b0, e_ack[0]});
    chk("ack3", {29'b0, ack3}, {28'b0, e_ack[1]});
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      m_ov[i] = n_ov[i]; m_od[i] = n_od[i]; m_oc[i] = n_oc[i]; m_p[i] = n_p[i]; m_se[i] = n_se[i];
    end
    chk("ov4", {31'b0, ov4}, {31'b0, m_ov[0]});
    chk("od4", od4, m_od[0]);
    chk("oc4", {30'b0, oc4}, 32'(m_oc[0]));
    chk("se4", {31'b0, se4}, {31'b0, m_se[0]});
    chk("ov3", {31'b0, ov3}, {31'b0, m_ov[1]});
    chk("od3", od3, m_od[1]);
    chk("oc3", {30'b0, oc3}, 32'(m_oc[1]));
    chk("se3", {31'b0, se3}, {31'b0, m_se[1]});
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_ov[i] = 0; m_od[i] = 0; m_oc[i] = 0; m_p[i] = 0; m_se[i] = 0;
    end
    for (int k = 0; k < 4; k++) in_data[k*W +: W] = 32'hA5A5_0000 + 32'(k);
    rst_n = 0; in_valid = 4'b1111; mode = 0; sel = 0; out_ready = 0;

    // Reset
    step(); step();
    chk("rst_ov", {31'b0, ov4}, 32'd0);
    chk("rst_od", od4, 32'd0);
    chk("rst_ack", {28'b0, last_ack4}, 32'd0);
    rst_n = 1; sel = 2; out_ready = 1;
    step();
    chk("first_od", od4, 32'hA5A5_0002);
    chk("first_oc", {30'b0, oc4}, 32'd2);
    chk("first_ack", {28'b0, last_ack4}, 32'b0100);

    // Direct stall then release
    out_ready = 0; sel = 1;
    repeat (3) begin
      step();
      chk("stall_od", od4, 32'hA5A5_0002);
      chk("stall_ack", {28'b0, last_ack4}, 32'd0);
    end
    out_ready = 1;
    step();
    chk("unstall_oc", {30'b0, oc4}, 32'd1);

    // Round-robin fairness
    mode = 1; in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_all", {30'b0, oc4}, 32'(i % 4));
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_alt", {30'b0, oc4}, (i % 2 == 0) ? 32'd1 : 32'd3);
    end

    // Gap wrap (pointer at 2) and drain
    in_valid = 4'b0001;
    step();
    chk("rr_wrap", {30'b0, oc4}, 32'd0);
    in_valid = 4'b0000;
    step();
    chk("drain_ov", {31'b0, ov4}, 32'd0);
    chk("drain_od", od4, 32'hA5A5_0000);

    // Out-of-range select on the 3-channel instance
    mode = 0; sel = 3;
    step();
    chk("selerr_hi", {31'b0, se3}, 32'd1);
    chk("selerr_4ch", {31'b0, se4}, 32'd0);
    sel = 0;
    step();
    chk("selerr_lo", {31'b0, se3}, 32'd0);
    mode = 1; sel = 3;
    step();
    chk("selerr_rr", {31'b0, se3}, 32'd0);

    // Reset mid-operation with pointer at 3
    in_valid = 4'b0100; out_ready = 1;
    step();
    out_ready = 0; in_valid = 4'b1111;
    step();
    rst_n = 0;
    step();
    chk("midrst_ov", {31'b0, ov4}, 32'd0);
    rst_n = 1; out_ready = 1;
    step();
    chk("midrst_first", {30'b0, oc4}, 32'd0);

    // Randomised traffic
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) in_data[k*W +: W] = $urandom;
      in_valid  = 4'($urandom);
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 39) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
